// File: rtl/rle_line_packer.sv
// Packs run-length runs into one 16-bit word packet per image line (header, runs, optional trailer).
// Define RLE_PACK_CHECKSUM_EN to append a trailer word carrying the 10-bit sum of run lengths.
module rle_line_packer #(
    parameter int LEN_W  = 10,
    parameter int LINE_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   frame_start,
    input  logic                   run_valid,
    input  logic [LEN_W-1:0]       run_len,
    input  logic                   run_colour,
    input  logic                   run_last,
    input  logic                   pkt_ready,
    output logic                   pkt_valid,
    output logic [15:0]            pkt_data,
    output logic                   pkt_sop,
    output logic                   pkt_eop,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = LEN_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        RUNS    = 2'd2,
        TRAILER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                overflow_q, overflow_d;
`ifdef RLE_PACK_CHECKSUM_EN
    logic [9:0]          sum_q, sum_d;
`endif

    logic [ENTRY_W-1:0]  head;
    logic [9:0]          head_len;
    logic                head_colour;
    logic                head_last;
    logic [9:0]          line_ext;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic [AW-1:0]       wr_idx;

    assign head        = mem_q[rd_ptr_q];
    assign head_len    = 10'(head[LEN_W-1:0]);
    assign head_colour = head[LEN_W];
    assign head_last   = head[LEN_W+1];
    assign line_ext    = 10'(line_q);
    assign empty       = (count_q == '0);
    assign full        = (count_q == (AW+1)'(DEPTH));

    // A flush empties the FIFO first, so a run arriving with frame_start always fits.
    assign push   = run_valid && (frame_start || !full);
    assign pop    = (state_q == RUNS) && !empty && pkt_ready && !frame_start;
    assign wr_idx = frame_start ? '0 : wr_ptr_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_idx] <= {run_last, run_colour, run_len};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            line_q     <= '0;
            overflow_q <= 1'b0;
`ifdef RLE_PACK_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            line_q     <= line_d;
            overflow_q <= overflow_d;
`ifdef RLE_PACK_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        line_d     = line_q;
        overflow_d = overflow_q;
`ifdef RLE_PACK_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (frame_start) begin
            state_d    = IDLE;
            wr_ptr_d   = AW'(push);
            rd_ptr_d   = '0;
            count_d    = (AW+1)'(push);
            line_d     = '0;
            overflow_d = 1'b0;
`ifdef RLE_PACK_CHECKSUM_EN
            sum_d      = '0;
`endif
        end else begin
            if (run_valid && full) begin
                overflow_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!empty) state_d = HEADER;
                end
                HEADER: begin
                    if (pkt_ready) state_d = RUNS;
                end
                RUNS: begin
                    if (pop) begin
`ifdef RLE_PACK_CHECKSUM_EN
                        sum_d = sum_q + head_len;
                        if (head_last) state_d = TRAILER;
`else
                        if (head_last) begin
                            line_d  = line_q + 1'b1;
                            state_d = IDLE;
                        end
`endif
                    end
                end
                TRAILER: begin
`ifdef RLE_PACK_CHECKSUM_EN
                    if (pkt_ready) begin
                        sum_d   = '0;
                        line_d  = line_q + 1'b1;
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stream outputs depend only on registered state and the FIFO head, so they hold while stalled.
    always_comb begin
        pkt_valid = 1'b0;
        pkt_data  = 16'h0000;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        case (state_q)
            HEADER: begin
                pkt_valid = 1'b1;
                pkt_sop   = 1'b1;
                pkt_data  = {2'b10, 4'b0000, line_ext};
            end
            RUNS: begin
                if (!empty) begin
                    pkt_valid = 1'b1;
                    pkt_data  = {1'b0, head_colour, 4'b0000, head_len};
`ifndef RLE_PACK_CHECKSUM_EN
                    pkt_eop   = head_last;
`endif
                end
            end
`ifdef RLE_PACK_CHECKSUM_EN
            TRAILER: begin
                pkt_valid = 1'b1;
                pkt_eop   = 1'b1;
                pkt_data  = {2'b11, 4'b0000, sum_q};
            end
`endif
            default: ;
        endcase
    end

    assign overflow   = overflow_q;
    assign fifo_level = count_q;

endmodule
